elevator_ctrl_n: RTL

N-floor elevator controller, successor to the two-floor controller. Hall up/down and in-car floor requests are latched and served in collective (SCAN) order. A travel timer moves the car one floor at a time and a door timer holds the door open at each stop. Sits between the debounced button/switch inputs and the LED/seven-segment display drivers on the 50 MHz board clock.

---
 rtl/elevator_pkg.sv | 18 +
 rtl/elev_cycle_timer.sv | 35 +++
 rtl/elevator_ctrl_n.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared encodings and default timing for the N-floor elevator controller.
package elevator_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_UP   = 2'b01,
      ST_DOWN = 2'b10,
      ST_DOOR = 2'b11
   } state_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   localparam int DEF_FLOORS        = 4;
   localparam int DEF_TRAVEL_CYCLES = 200_000_000;
   localparam int DEF_DOOR_CYCLES   = 100_000_000;
endpackage

// File: rtl/elev_cycle_timer.sv
// Free-running cycle counter shared by travel and door timing; the caller
// supplies the terminal count so one counter serves both phases.
module elev_cycle_timer #(
   parameter  int MAX = 4,
   localparam int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
   input  logic         clk_50mhz,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] last,
   output logic         done
);
   logic [W-1:0] cnt_q, cnt_d;

   // done does not look at clr so the caller can give clr priority itself
   assign done = en && (cnt_q == last);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = done ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor collective (SCAN) elevator controller: latches hall/car requests,
// moves one floor per travel period and holds the door for a fixed period.
module elevator_ctrl_n
   import elevator_pkg::*;
#(
   parameter  int FLOORS        = DEF_FLOORS,
   parameter  int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
   parameter  int DOOR_CYCLES   = DEF_DOOR_CYCLES,
   localparam int FW            = $clog2(FLOORS)
) (
   input  logic              clk_50mhz,
   input  logic              rst,
   input  logic              start_stop,
   input  logic [FLOORS-1:0] hall_up,
   input  logic [FLOORS-1:0] hall_down,
   input  logic [FLOORS-1:0] car_req,
   output logic [FW-1:0]     floor,
   output logic [1:0]        state,
   output logic              door_open,
   output logic [FLOORS-1:0] up_lamps,
   output logic [FLOORS-1:0] down_lamps,
   output logic [FLOORS-1:0] car_lamps
);
   localparam int CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   state_e            state_q, state_d;
   dir_e              dir_q, dir_d;
   logic [FW-1:0]     floor_q, floor_d;
   logic [FLOORS-1:0] up_q, up_d, down_q, down_d, car_q, car_d;
   logic              door_q, door_d;

   logic [FLOORS-1:0] all_req, up_set, down_set, car_set, up_clr, down_clr, car_clr;
   logic [FLOORS-1:0] here_oh, nxt_up_oh, nxt_dn_oh;
   logic              above, below, here, beyond_up, beyond_dn, hit_up, hit_dn;
   logic              press_here, door_restart;
   logic              tmr_en, tmr_clr, tmr_done;
   logic [CW-1:0]     tmr_last;
   int                fi;

   assign tmr_en   = start_stop && (state_q != ST_IDLE);
   assign tmr_clr  = (state_q == ST_IDLE) || door_restart;
   assign tmr_last = (state_q == ST_DOOR) ? CW'(DOOR_CYCLES - 1) : CW'(TRAVEL_CYCLES - 1);

   elev_cycle_timer #(.MAX(CMAX)) u_timer (
      .clk_50mhz (clk_50mhz),
      .rst       (rst),
      .en        (tmr_en),
      .clr       (tmr_clr),
      .last      (tmr_last),
      .done      (tmr_done)
   );

   always_comb begin
      fi       = int'(floor_q);
      all_req  = up_q | down_q | car_q;
      up_set   = hall_up;
      up_set[FLOORS-1] = 1'b0;
      down_set = hall_down;
      down_set[0] = 1'b0;
      car_set  = car_req;
      above = 1'b0; below = 1'b0; here = 1'b0; beyond_up = 1'b0; beyond_dn = 1'b0;
      hit_up = 1'b0; hit_dn = 1'b0; press_here = 1'b0;
      here_oh = '0; nxt_up_oh = '0; nxt_dn_oh = '0;
      // "beyond" is measured from the floor the car is about to reach
      for (int i = 0; i < FLOORS; i++) begin
         if (all_req[i]) begin
            if (i > fi)     above     = 1'b1;
            if (i < fi)     below     = 1'b1;
            if (i == fi)    here      = 1'b1;
            if (i > fi + 1) beyond_up = 1'b1;
            if (i < fi - 1) beyond_dn = 1'b1;
         end
         if (i == fi) begin
            here_oh[i] = 1'b1;
            press_here = up_set[i] | down_set[i] | car_set[i];
         end
         if (i == fi + 1) begin
            nxt_up_oh[i] = 1'b1;
            hit_up       = car_q[i] | up_q[i];
         end
         if (i == fi - 1) begin
            nxt_dn_oh[i] = 1'b1;
            hit_dn       = car_q[i] | down_q[i];
         end
      end

      state_d = state_q; floor_d = floor_q; dir_d = dir_q; door_restart = 1'b0;
      up_clr = '0; down_clr = '0; car_clr = '0;
      if (start_stop) begin
         case (state_q)
            ST_IDLE: begin
               if (here) begin
                  state_d = ST_DOOR;
                  up_clr = here_oh; down_clr = here_oh; car_clr = here_oh;
               end else if (dir_q == DIR_UP) begin
                  if (above)      state_d = ST_UP;
                  else if (below) state_d = ST_DOWN;
               end else begin
                  if (below)      state_d = ST_DOWN;
                  else if (above) state_d = ST_UP;
               end
            end
            ST_UP: begin
               if (tmr_done) begin
                  floor_d = floor_q + FW'(1);
                  dir_d   = DIR_UP;
                  if (hit_up || !beyond_up) begin
                     state_d = ST_DOOR;
                     car_clr = nxt_up_oh;
                     up_clr  = nxt_up_oh;
                     if (!beyond_up) down_clr = nxt_up_oh;
                  end
               end
            end
            ST_DOWN: begin
               if (tmr_done) begin
                  floor_d  = floor_q - FW'(1);
                  dir_d    = DIR_DOWN;
                  if (hit_dn || !beyond_dn) begin
                     state_d  = ST_DOOR;
                     car_clr  = nxt_dn_oh;
                     down_clr = nxt_dn_oh;
                     if (!beyond_dn) up_clr = nxt_dn_oh;
                  end
               end
            end
            default: begin
               if (press_here)    door_restart = 1'b1;
               else if (tmr_done) state_d = ST_IDLE;
            end
         endcase
      end

      // presses for the floor whose door is open are absorbed, never latched
      if (state_q == ST_DOOR) begin
         up_set   = up_set & ~here_oh;
         down_set = down_set & ~here_oh;
         car_set  = car_set & ~here_oh;
      end
      up_d   = (up_q | up_set) & ~up_clr;
      down_d = (down_q | down_set) & ~down_clr;
      car_d  = (car_q | car_set) & ~car_clr;
      door_d = (state_d == ST_DOOR);
   end

   always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_UP;
         floor_q <= '0;
         up_q    <= '0;
         down_q  <= '0;
         car_q   <= '0;
         door_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         floor_q <= floor_d;
         up_q    <= up_d;
         down_q  <= down_d;
         car_q   <= car_d;
         door_q  <= door_d;
      end
   end

   assign floor      = floor_q;
   assign state      = state_q;
   assign door_open  = door_q;
   assign up_lamps   = up_q;
   assign down_lamps = down_q;
   assign car_lamps  = car_q;
endmodule
